// File: rtl/mdu_pkg.sv
// Shared types and constants for the iterative multiply/divide unit.
package mdu_pkg;

    localparam int MDU_WIDTH = 32;
    localparam int MDU_ITERS = 32;
    localparam int MDU_CNT_W = 5;

    // Quotient reported for a zero divisor, DIV and DIVU alike.
    localparam logic [MDU_WIDTH-1:0] DIV0_QUOT = {MDU_WIDTH{1'b1}};

    typedef enum logic [1:0] {
        OP_MULT  = 2'b00,
        OP_MULTU = 2'b01,
        OP_DIV   = 2'b10,
        OP_DIVU  = 2'b11
    } mdu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_CALC = 2'b01,
        ST_FIX  = 2'b10,
        ST_DONE = 2'b11
    } mdu_state_e;

endpackage

// File: rtl/mul_div_unit_add.sv
// ADD: the ALU's plain ripple adder, reused by the MDU as its per-iteration
// add (multiply) and trial subtract (divide, via ~b and c_in = 1).
module ADD #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    output logic [WIDTH-1:0] sum,
    output logic             c_out
);

    // Full-width add with carry in and carry out.
    assign {c_out, sum} = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, c_in};

endmodule

// File: rtl/mul_div_unit.sv
// mul_div_unit: 34-cycle iterative MULT/MULTU/DIV/DIVU with HI/LO registers
// and MTHI/MTLO write port. Define MDU_DIV_EN to build the divider; without it
// divide requests are ignored and only multiply is available.
import mdu_pkg::*;

module mul_div_unit #(
    parameter int WIDTH = MDU_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             wr_hi,
    input  logic             wr_lo,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam logic [MDU_CNT_W-1:0] LAST_ITER = MDU_CNT_W'(MDU_ITERS - 1);
    localparam logic [MDU_CNT_W-1:0] ZERO_CNT  = {MDU_CNT_W{1'b0}};
    localparam logic [MDU_CNT_W-1:0] ONE_CNT   = {{(MDU_CNT_W-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0]     ZERO_W    = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0]     ONE_W     = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [2*WIDTH-1:0]   ONE_2W    = {{(2*WIDTH-1){1'b0}}, 1'b1};
`ifdef MDU_DIV_EN
    // All-ones at whatever width the unit is built for.
    localparam logic [WIDTH-1:0]     QUOT_DIV0 = {WIDTH{DIV0_QUOT[0]}};
`endif

    // Two's-complement negate when neg is set.
    function automatic logic [WIDTH-1:0] neg_if(input logic [WIDTH-1:0] v, input logic neg);
        return neg ? (~v + ONE_W) : v;
    endfunction

    mdu_state_e             state_r, state_nxt_s;
    logic [MDU_CNT_W-1:0]   cnt_r;
    mdu_op_e                op_r;
    logic                   sign_a_r, sign_b_r;
    logic [WIDTH-1:0]       opb_r;      // multiplicand or divisor magnitude
    logic [2*WIDTH-1:0]     acc_r;      // {upper, lower} shift accumulator
    logic                   busy_r, done_r, busy_nxt_s, done_nxt_s;
    logic [WIDTH-1:0]       hi_r, lo_r;

    logic                   op_ok_s, in_flight_s, accept_s;
    logic                   sa_in_s, sb_in_s;
    logic [WIDTH-1:0]       a_mag_s, b_mag_s, init_lo_s, init_opb_s;
    logic [WIDTH-1:0]       add_a_s, add_b_s, add_sum_s;
    logic                   add_cin_s, add_cout_s;
    logic [2*WIDTH-1:0]     acc_step_s, prod_s;
    logic [WIDTH-1:0]       res_hi_s, res_lo_s;
`ifdef MDU_DIV_EN
    logic                   b_zero_r;
    logic                   is_div_s, fit_s;
    assign op_ok_s  = 1'b1;
    assign is_div_s = (op_r == OP_DIV) || (op_r == OP_DIVU);
    // Trial subtract fits when the shifted-out remainder bit is set or no borrow.
    assign fit_s    = acc_r[2*WIDTH-1] | add_cout_s;
`else
    // Divide requests are dropped entirely when the divider is not built.
    assign op_ok_s  = ~op[1];
`endif

    assign in_flight_s = (state_r == ST_CALC) || (state_r == ST_FIX);
    assign accept_s    = start & op_ok_s & ~in_flight_s;

    // Signed ops (op[0] == 0) work on magnitudes.
    assign sa_in_s = ~op[0] & A[WIDTH-1];
    assign sb_in_s = ~op[0] & B[WIDTH-1];
    assign a_mag_s = neg_if(A, sa_in_s);
    assign b_mag_s = neg_if(B, sb_in_s);

    // Route magnitudes: multiplier/dividend into the accumulator, the other into opb.
    always_comb begin
        init_lo_s  = b_mag_s;
        init_opb_s = a_mag_s;
`ifdef MDU_DIV_EN
        if (op[1]) begin
            init_lo_s  = a_mag_s;
            init_opb_s = b_mag_s;
        end else begin
            init_lo_s  = b_mag_s;
            init_opb_s = a_mag_s;
        end
`endif
    end

    // Adder operands: conditional add for multiply, A + ~B + 1 for divide.
    always_comb begin
        add_a_s   = acc_r[2*WIDTH-1:WIDTH];
        add_b_s   = acc_r[0] ? opb_r : ZERO_W;
        add_cin_s = 1'b0;
`ifdef MDU_DIV_EN
        if (is_div_s) begin
            add_a_s   = acc_r[2*WIDTH-2:WIDTH-1];
            add_b_s   = ~opb_r;
            add_cin_s = 1'b1;
        end else begin
            add_a_s   = acc_r[2*WIDTH-1:WIDTH];
            add_b_s   = acc_r[0] ? opb_r : ZERO_W;
            add_cin_s = 1'b0;
        end
`endif
    end

    ADD #(.WIDTH(WIDTH)) u_add (
        .a     (add_a_s),
        .b     (add_b_s),
        .c_in  (add_cin_s),
        .sum   (add_sum_s),
        .c_out (add_cout_s)
    );

    // One iteration: shift-add for multiply, restoring shift-subtract for divide.
    always_comb begin
        acc_step_s = {add_cout_s, add_sum_s, acc_r[WIDTH-1:1]};
`ifdef MDU_DIV_EN
        if (is_div_s) begin
            acc_step_s = {(fit_s ? add_sum_s : acc_r[2*WIDTH-2:WIDTH-1]), acc_r[WIDTH-2:0], fit_s};
        end else begin
            acc_step_s = {add_cout_s, add_sum_s, acc_r[WIDTH-1:1]};
        end
`endif
    end

    // Sign correction of the finished accumulator into HI/LO values.
    always_comb begin
        prod_s   = ((op_r == OP_MULT) && (sign_a_r ^ sign_b_r)) ? (~acc_r + ONE_2W) : acc_r;
        res_hi_s = prod_s[2*WIDTH-1:WIDTH];
        res_lo_s = prod_s[WIDTH-1:0];
`ifdef MDU_DIV_EN
        if (is_div_s) begin
            // Zero divisor leaves the remainder equal to |A|, so HI restores A.
            res_lo_s = b_zero_r ? QUOT_DIV0 : neg_if(acc_r[WIDTH-1:0], sign_a_r ^ sign_b_r);
            res_hi_s = neg_if(acc_r[2*WIDTH-1:WIDTH], sign_a_r);
        end else begin
            res_hi_s = prod_s[2*WIDTH-1:WIDTH];
            res_lo_s = prod_s[WIDTH-1:0];
        end
`endif
    end

    // State register plus registered busy/done flags.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            busy_r  <= busy_nxt_s;
            done_r  <= done_nxt_s;
        end
    end

    // Next-state logic: DONE accepts a new start exactly like IDLE.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE, ST_DONE: begin
                if (accept_s) state_nxt_s = ST_CALC;
                else          state_nxt_s = ST_IDLE;
            end
            ST_CALC: begin
                if (cnt_r == LAST_ITER) state_nxt_s = ST_FIX;
                else                    state_nxt_s = ST_CALC;
            end
            ST_FIX:  state_nxt_s = ST_DONE;
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // Output decode of the upcoming state, registered above.
    always_comb begin
        busy_nxt_s = 1'b0;
        done_nxt_s = 1'b0;
        case (state_nxt_s)
            ST_CALC, ST_FIX: busy_nxt_s = 1'b1;
            ST_DONE:         done_nxt_s = 1'b1;
            default: begin
                busy_nxt_s = 1'b0;
                done_nxt_s = 1'b0;
            end
        endcase
    end

    // Operand capture on accept and one accumulator step per CALC cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_r    <= ZERO_CNT;
            op_r     <= OP_MULT;
            sign_a_r <= 1'b0;
            sign_b_r <= 1'b0;
            opb_r    <= ZERO_W;
            acc_r    <= {ZERO_W, ZERO_W};
`ifdef MDU_DIV_EN
            b_zero_r <= 1'b0;
`endif
        end else if (accept_s) begin
            cnt_r    <= ZERO_CNT;
            op_r     <= mdu_op_e'(op);
            sign_a_r <= sa_in_s;
            sign_b_r <= sb_in_s;
            opb_r    <= init_opb_s;
            acc_r    <= {ZERO_W, init_lo_s};
`ifdef MDU_DIV_EN
            b_zero_r <= (B == ZERO_W);
`endif
        end else if (state_r == ST_CALC) begin
            acc_r <= acc_step_s;
            cnt_r <= cnt_r + ONE_CNT;
        end
    end

    // HI/LO: result commit in FIX, otherwise MTHI/MTLO when not busy.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hi_r <= ZERO_W;
            lo_r <= ZERO_W;
        end else if (state_r == ST_FIX) begin
            hi_r <= res_hi_s;
            lo_r <= res_lo_s;
        end else if (!in_flight_s) begin
            if (wr_hi) hi_r <= wdata;
            if (wr_lo) lo_r <= wdata;
        end
    end

    assign busy = busy_r;
    assign done = done_r;
    assign hi   = hi_r;
    assign lo   = lo_r;

endmodule
